// File: rtl/buffered_io_port_pkg.sv
// buffered_io_port shared definitions.
// Status bit positions and sizing helpers.
package buffered_io_port_pkg;

  localparam int ST_IN_OVR  = 0;
  localparam int ST_IN_UND  = 1;
  localparam int ST_OUT_OVR = 2;
  localparam int ST_W       = 3;

  typedef logic [ST_W-1:0] status_t;

endpackage

// File: rtl/port_fifo.sv
// Count-based circular FIFO with reset storage.
// Optional push-on-pop when full (slot freed same edge).
module port_fifo
  import buffered_io_port_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit ALLOW_FULL_PUSH_ON_POP = 1'b0,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Next-state: popped slot is zeroed so an empty FIFO reads 0.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o ||
              (ALLOW_FULL_PUSH_ON_POP && do_pop));
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_pop) begin
      mem_d[rd_q] = '0;
      rd_d = rd_q + 1'b1;
    end
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d = wr_q + 1'b1;
    end
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/buffered_io_port.sv
// Buffered I/O port: input and output FIFOs
// between device handshakes and the CPU bus.
module buffered_io_port
  import buffered_io_port_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                           Clock,
  input  logic                           Clear,
  input  logic [WIDTH-1:0]               In_Data,
  input  logic                           Strobe,
  output logic                           In_Ready,
  input  logic                           InPortOut,
  output logic [WIDTH-1:0]               BusMuxIn_In,
  input  logic [WIDTH-1:0]               BusMuxOut,
  input  logic                           OutPortIn,
  output logic [WIDTH-1:0]               Out_Data,
  output logic                           Out_Valid,
  input  logic                           Out_Ack,
  output logic [$clog2(IN_DEPTH+1)-1:0]  InCount,
  output logic [$clog2(OUT_DEPTH+1)-1:0] OutCount,
  input  logic                           StatusClr,
  output logic [2:0]                     Status
);

  logic [WIDTH-1:0] in_head;
  logic             in_full, in_empty;
  logic             out_full, out_empty;
  status_t          status_q, status_d;

  port_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(IN_DEPTH),
    .ALLOW_FULL_PUSH_ON_POP(1'b0)
  ) u_in_fifo (
    .clk    (Clock),
    .rst_n  (Clear),
    .push_i (Strobe),
    .pop_i  (InPortOut),
    .din_i  (In_Data),
    .head_o (in_head),
    .count_o(InCount),
    .full_o (in_full),
    .empty_o(in_empty)
  );

  port_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(OUT_DEPTH),
    .ALLOW_FULL_PUSH_ON_POP(1'b1)
  ) u_out_fifo (
    .clk    (Clock),
    .rst_n  (Clear),
    .push_i (OutPortIn),
    .pop_i  (Out_Ack),
    .din_i  (BusMuxOut),
    .head_o (Out_Data),
    .count_o(OutCount),
    .full_o (out_full),
    .empty_o(out_empty)
  );

  assign In_Ready    = !in_full;
  assign Out_Valid   = !out_empty;
  assign BusMuxIn_In = in_empty ? '0 : in_head;
  assign Status      = status_q;

  // Sticky flags: a same-cycle event beats the clear.
  always_comb begin
    status_d = StatusClr ? '0 : status_q;
    if (Strobe && in_full)
      status_d[ST_IN_OVR] = 1'b1;
    if (InPortOut && in_empty)
      status_d[ST_IN_UND] = 1'b1;
    if (OutPortIn && out_full && !Out_Ack)
      status_d[ST_OUT_OVR] = 1'b1;
  end

  // Status register.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) status_q <= '0;
    else        status_q <= status_d;
  end

endmodule

// File: tb/tb_buffered_io_port.sv
// Self-checking bench for buffered_io_port.
// Scoreboard queues per FIFO, one task per scenario.
module tb_buffered_io_port;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] In_Data;
  logic        Strobe;
  logic        In_Ready;
  logic        InPortOut;
  logic [31:0] BusMuxIn_In;
  logic [31:0] BusMuxOut;
  logic        OutPortIn;
  logic [31:0] Out_Data;
  logic        Out_Valid;
  logic        Out_Ack;
  logic [2:0]  InCount;
  logic [2:0]  OutCount;
  logic        StatusClr;
  logic [2:0]  Status;

  int errors = 0;
  int checks = 0;
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  logic [31:0] exp_w;

  buffered_io_port #(
    .WIDTH(32), .IN_DEPTH(4), .OUT_DEPTH(4)
  ) dut (
    .Clock(Clock), .Clear(Clear),
    .In_Data(In_Data), .Strobe(Strobe),
    .In_Ready(In_Ready), .InPortOut(InPortOut),
    .BusMuxIn_In(BusMuxIn_In), .BusMuxOut(BusMuxOut),
    .OutPortIn(OutPortIn), .Out_Data(Out_Data),
    .Out_Valid(Out_Valid), .Out_Ack(Out_Ack),
    .InCount(InCount), .OutCount(OutCount),
    .StatusClr(StatusClr), .Status(Status)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Strobe = 0; InPortOut = 0; OutPortIn = 0;
    Out_Ack = 0; StatusClr = 0;
  endtask

  task automatic test_reset();
    Clear = 0; In_Data = 0; BusMuxOut = 0;
    idle();
    #1;
    checks++;
    if ({In_Ready, Out_Valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs got %b exp 10", {In_Ready, Out_Valid});
    end
    step(); Clear = 1; step();
    Strobe = 1; In_Data = 32'h55;
    OutPortIn = 1; BusMuxOut = 32'h66;
    step(); idle();
    checks++;
    if (InCount !== 3'd1 || OutCount !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset_cnt got %0d/%0d exp 1/1", InCount, OutCount);
    end
    #2 Clear = 0;
    #1;
    checks++;
    if (BusMuxIn_In !== 0 || Out_Data !== 0 || InCount !== 0 ||
        OutCount !== 0 || Status !== 0 || In_Ready !== 1 ||
        Out_Valid !== 0) begin
      errors++;
      $display("FAIL async_reset bus=%h out=%h ic=%0d oc=%0d st=%b rdy=%b vld=%b exp zeros rdy=1 vld=0",
               BusMuxIn_In, Out_Data, InCount, OutCount, Status,
               In_Ready, Out_Valid);
    end
    step(); Clear = 1;
    Strobe = 1; In_Data = 32'h5A; in_q.push_back(32'h5A);
    step(); idle();
    checks++;
    if (InCount !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_cnt got %0d exp 1", InCount);
    end
    InPortOut = 1; #1;
    exp_w = in_q.pop_front();
    checks++;
    if (BusMuxIn_In !== exp_w) begin
      errors++;
      $display("FAIL post_reset_data got %h exp %h", BusMuxIn_In, exp_w);
    end
    step(); idle();
  endtask

  task automatic test_in_fill();
    for (int i = 0; i < 5; i++) begin
      Strobe = 1; In_Data = 32'hA1 + i;
      #1;
      checks++;
      if (In_Ready !== (i < 4)) begin
        errors++;
        $display("FAIL in_ready[%0d] got %b exp %b", i, In_Ready, i < 4);
      end
      if (i < 4) in_q.push_back(In_Data);
      step();
    end
    idle();
    checks++;
    if (InCount !== 3'd4 || Status !== 3'b001) begin
      errors++;
      $display("FAIL in_overrun cnt=%0d st=%b exp 4 001", InCount, Status);
    end
    for (int k = 0; k < 4; k++) begin
      InPortOut = 1; #1;
      exp_w = in_q.pop_front();
      checks++;
      if (BusMuxIn_In !== exp_w || InCount !== 3'(4 - k)) begin
        errors++;
        $display("FAIL in_drain[%0d] got %h/%0d exp %h/%0d",
                 k, BusMuxIn_In, InCount, exp_w, 4 - k);
      end
      step();
    end
    idle();
    checks++;
    if (InCount !== 0 || In_Ready !== 1) begin
      errors++;
      $display("FAIL in_empty cnt=%0d rdy=%b exp 0 1", InCount, In_Ready);
    end
  endtask

  task automatic test_underrun();
    StatusClr = 1; step(); idle();
    checks++;
    if (Status !== 0) begin
      errors++;
      $display("FAIL clr_ovr got %b exp 000", Status);
    end
    InPortOut = 1; #1;
    checks++;
    if (BusMuxIn_In !== 0) begin
      errors++;
      $display("FAIL und_bus got %h exp 0", BusMuxIn_In);
    end
    step(); idle();
    checks++;
    if (Status !== 3'b010) begin
      errors++;
      $display("FAIL und_flag got %b exp 010", Status);
    end
    StatusClr = 1; step(); idle();
    checks++;
    if (Status !== 0) begin
      errors++;
      $display("FAIL clr_und got %b exp 000", Status);
    end
    StatusClr = 1; InPortOut = 1; step(); idle();
    checks++;
    if (Status !== 3'b010) begin
      errors++;
      $display("FAIL clr_vs_event got %b exp 010", Status);
    end
    Strobe = 1; In_Data = 32'h77; InPortOut = 1;
    StatusClr = 1; #1;
    checks++;
    if (BusMuxIn_In !== 0) begin
      errors++;
      $display("FAIL no_bypass got %h exp 0", BusMuxIn_In);
    end
    in_q.push_back(32'h77);
    step(); idle();
    exp_w = in_q.pop_front();
    checks++;
    if (InCount !== 1 || BusMuxIn_In !== exp_w || Status !== 3'b010) begin
      errors++;
      $display("FAIL push_empty cnt=%0d bus=%h st=%b exp 1 %h 010",
               InCount, BusMuxIn_In, Status, exp_w);
    end
    InPortOut = 1; StatusClr = 1; step(); idle();
  endtask

  task automatic test_out_full();
    for (int i = 0; i < 4; i++) begin
      OutPortIn = 1; BusMuxOut = 32'h10 + i;
      out_q.push_back(BusMuxOut);
      step();
    end
    idle();
    checks++;
    if (OutCount !== 4 || Out_Valid !== 1 || Out_Data !== out_q[0]) begin
      errors++;
      $display("FAIL out_fill cnt=%0d vld=%b data=%h exp 4 1 %h",
               OutCount, Out_Valid, Out_Data, out_q[0]);
    end
    OutPortIn = 1; BusMuxOut = 32'h14; Out_Ack = 1; #1;
    exp_w = out_q.pop_front();
    checks++;
    if (Out_Data !== exp_w) begin
      errors++;
      $display("FAIL out_ack_head got %h exp %h", Out_Data, exp_w);
    end
    out_q.push_back(32'h14);
    step(); idle();
    checks++;
    if (OutCount !== 4 || Status !== 0) begin
      errors++;
      $display("FAIL full_push_pop cnt=%0d st=%b exp 4 000", OutCount, Status);
    end
    OutPortIn = 1; BusMuxOut = 32'h15; step(); idle();
    checks++;
    if (OutCount !== 4 || Status !== 3'b100) begin
      errors++;
      $display("FAIL out_overrun cnt=%0d st=%b exp 4 100", OutCount, Status);
    end
    for (int k = 0; k < 4; k++) begin
      Out_Ack = 1; #1;
      exp_w = out_q.pop_front();
      checks++;
      if (Out_Data !== exp_w) begin
        errors++;
        $display("FAIL out_drain[%0d] got %h exp %h", k, Out_Data, exp_w);
      end
      step();
    end
    Out_Ack = 1; step(); idle();
    checks++;
    if (OutCount !== 0 || Out_Valid !== 0 || Out_Data !== 0) begin
      errors++;
      $display("FAIL out_empty cnt=%0d vld=%b data=%h exp 0 0 0",
               OutCount, Out_Valid, Out_Data);
    end
    StatusClr = 1; step(); idle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 22; c++) begin
      Strobe    = (c < 20);
      OutPortIn = (c < 20);
      In_Data   = 32'hC000_0000 + c;
      BusMuxOut = 32'hD000_0000 + c;
      InPortOut = (c >= 2);
      Out_Ack   = (c >= 2);
      #1;
      checks++;
      if (InCount !== 3'(in_q.size()) ||
          OutCount !== 3'(out_q.size())) begin
        errors++;
        $display("FAIL stream_cnt[%0d] got %0d/%0d exp %0d/%0d", c,
                 InCount, OutCount, in_q.size(), out_q.size());
      end
      if (c >= 2) begin
        exp_w = in_q.pop_front();
        checks++;
        if (BusMuxIn_In !== exp_w) begin
          errors++;
          $display("FAIL stream_in[%0d] got %h exp %h", c, BusMuxIn_In, exp_w);
        end
        exp_w = out_q.pop_front();
        checks++;
        if (Out_Data !== exp_w) begin
          errors++;
          $display("FAIL stream_out[%0d] got %h exp %h", c, Out_Data, exp_w);
        end
      end
      if (c < 20) begin
        in_q.push_back(In_Data);
        out_q.push_back(BusMuxOut);
      end
      step();
    end
    idle();
    checks++;
    if (InCount !== 0 || OutCount !== 0 || Status !== 0) begin
      errors++;
      $display("FAIL stream_end ic=%0d oc=%0d st=%b exp 0 0 000",
               InCount, OutCount, Status);
    end
  endtask

  initial begin
    test_reset();
    test_in_fill();
    test_underrun();
    test_out_full();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
